// File: rtl/dct_ctrl_axil_slave.sv
// rtl/dct_ctrl_axil_slave.sv - AXI4-Lite control/status register file for the 4x4 DCT accelerator
// AW and W are captured independently; reads are one-outstanding; DONE is sticky W1C.
module dct_ctrl_axil_slave #(
   parameter int          ADDR_W  = 12,
   parameter logic [31:0] VERSION = 32'h0001_0000
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic              start_o,
   output logic [31:0]       src_addr_o,
   output logic [31:0]       dst_addr_o,
   output logic [15:0]       len_o,
   input  logic              busy_i,
   input  logic              done_i,
   output logic              irq_o
);

   localparam logic [2:0] IDX_CTRL    = 3'd0;
   localparam logic [2:0] IDX_STATUS  = 3'd1;
   localparam logic [2:0] IDX_SRC     = 3'd2;
   localparam logic [2:0] IDX_DST     = 3'd3;
   localparam logic [2:0] IDX_LEN     = 3'd4;
   localparam logic [2:0] IDX_VERSION = 3'd5;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic              aw_held_q, aw_held_d;
   logic [ADDR_W-1:2] aw_addr_q, aw_addr_d;
   logic              w_held_q, w_held_d;
   logic [31:0]       w_data_q, w_data_d;
   logic [3:0]        w_strb_q, w_strb_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              start_q, start_d;
   logic              irq_en_q, irq_en_d;
   logic              done_q, done_d;
   logic              irq_q, irq_d;
   logic [31:0]       src_q, src_d;
   logic [31:0]       dst_q, dst_d;
   logic [15:0]       len_q, len_d;

   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_exec, done_clr;
   logic [31:0] rd_val;
   logic        unused_ok;

   // Anything above 0x014 is unmapped, including aliases that reuse addr[4:2].
   function automatic logic is_mapped(input logic [ADDR_W-1:2] a);
      return (a[ADDR_W-1:5] == '0) && (a[4:2] < 3'd6);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      end
      return r;
   endfunction

   assign aw_hs     = s_axi_awvalid & awready_q;
   assign w_hs      = s_axi_wvalid & wready_q;
   assign b_hs      = bvalid_q & s_axi_bready;
   assign ar_hs     = s_axi_arvalid & arready_q;
   assign r_hs      = rvalid_q & s_axi_rready;
   assign wr_exec   = aw_held_q & w_held_q & ~bvalid_q;
   assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   always_comb begin
      aw_held_d = aw_held_q;
      aw_addr_d = aw_addr_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      start_d   = 1'b0;
      irq_en_d  = irq_en_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      done_clr  = 1'b0;
      rd_val    = '0;
      irq_d     = irq_en_q & done_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_addr_d = s_axi_awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = s_axi_wdata;
         w_strb_d = s_axi_wstrb;
      end

      if (wr_exec) begin
         bvalid_d = 1'b1;
         bresp_d  = is_mapped(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
         if (is_mapped(aw_addr_q)) begin
            case (aw_addr_q[4:2])
               IDX_CTRL: begin
                  if (w_strb_q[0]) begin
                     irq_en_d = w_data_q[1];
                     start_d  = w_data_q[0] & ~busy_i;
                  end
               end
               IDX_STATUS: done_clr = w_strb_q[0] & w_data_q[1];
               IDX_SRC:    src_d = merge(src_q, w_data_q, w_strb_q);
               IDX_DST:    dst_d = merge(dst_q, w_data_q, w_strb_q);
               IDX_LEN: begin
                  if (w_strb_q[0]) len_d[7:0]  = w_data_q[7:0];
                  if (w_strb_q[1]) len_d[15:8] = w_data_q[15:8];
               end
               default: ;
            endcase
         end
      end

      if (b_hs) begin
         bvalid_d  = 1'b0;
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end

      // A completion arriving alongside a clear must not be lost.
      done_d = done_i ? 1'b1 : (done_clr ? 1'b0 : done_q);

      awready_d = ~aw_held_d & ~bvalid_d;
      wready_d  = ~w_held_d & ~bvalid_d;

      if (is_mapped(s_axi_araddr[ADDR_W-1:2])) begin
         case (s_axi_araddr[4:2])
            IDX_CTRL:    rd_val = {30'h0, irq_en_q, 1'b0};
            IDX_STATUS:  rd_val = {30'h0, done_q, busy_i};
            IDX_SRC:     rd_val = src_q;
            IDX_DST:     rd_val = dst_q;
            IDX_LEN:     rd_val = {16'h0, len_q};
            IDX_VERSION: rd_val = VERSION;
            default:     rd_val = '0;
         endcase
      end

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_val;
         rresp_d  = is_mapped(s_axi_araddr[ADDR_W-1:2]) ? RESP_OKAY : RESP_SLVERR;
      end else if (r_hs) begin
         rvalid_d = 1'b0;
      end
      arready_d = ~rvalid_d;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_held_q <= 1'b0;
         aw_addr_q <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         start_q   <= 1'b0;
         irq_en_q  <= 1'b0;
         done_q    <= 1'b0;
         irq_q     <= 1'b0;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
      end else begin
         aw_held_q <= aw_held_d;
         aw_addr_q <= aw_addr_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         start_q   <= start_d;
         irq_en_q  <= irq_en_d;
         done_q    <= done_d;
         irq_q     <= irq_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign start_o       = start_q;
   assign src_addr_o    = src_q;
   assign dst_addr_o    = dst_q;
   assign len_o         = len_q;
   assign irq_o         = irq_q;

endmodule

// File: tb/tb_dct_ctrl_axil_slave.sv
// tb/tb_dct_ctrl_axil_slave.sv - self-checking bench for dct_ctrl_axil_slave
// Expected B/R responses are queued when a request is issued and popped when the DUT answers.
module tb_dct_ctrl_axil_slave;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [11:0] s_axi_awaddr = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b1;
   logic [11:0] s_axi_araddr = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b1;
   logic        start_o;
   logic [31:0] src_addr_o;
   logic [31:0] dst_addr_o;
   logic [15:0] len_o;
   logic        busy_i = 1'b0;
   logic        done_i = 1'b0;
   logic        irq_o;

   int vectors = 0;
   int miscompares = 0;
   int start_cnt = 0;
   logic [1:0]  exp_b[$];
   logic [33:0] exp_r[$];

   dct_ctrl_axil_slave #(.ADDR_W(12), .VERSION(32'h0001_0000)) dut (
      .aclk(aclk), .areset(areset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready),
      .start_o(start_o), .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .len_o(len_o),
      .busy_i(busy_i), .done_i(done_i), .irq_o(irq_o)
   );

   always #5 aclk = ~aclk;

   always @(negedge aclk) if (start_o) start_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   function automatic logic is_mapped(input logic [11:0] a);
      return (a[11:5] == 7'h0) && (a[4:2] < 3'd6);
   endfunction

   task automatic send_aw_w(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit pulse_done);
      int n = 0;
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      while (!(s_axi_awready && s_axi_wready) && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin
         vectors++; miscompares++;
         $display("FAIL aw_w_ready_timeout: actual=%b%b required=11", s_axi_awready, s_axi_wready);
      end
      @(negedge aclk);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      if (pulse_done) begin
         done_i = 1'b1;
         @(negedge aclk);
         done_i = 1'b0;
      end
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
      while (!s_axi_wready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin
         vectors++; miscompares++;
         $display("FAIL w_ready_timeout: actual=0 required=1");
      end
      @(negedge aclk);
      s_axi_wvalid = 1'b0;
   endtask

   task automatic send_aw(input logic [11:0] a);
      int n = 0;
      s_axi_awaddr = a; s_axi_awvalid = 1'b1;
      while (!s_axi_awready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin
         vectors++; miscompares++;
         $display("FAIL aw_ready_timeout: actual=0 required=1");
      end
      @(negedge aclk);
      s_axi_awvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [11:0] a);
      int n = 0;
      s_axi_araddr = a; s_axi_arvalid = 1'b1;
      while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin
         vectors++; miscompares++;
         $display("FAIL ar_ready_timeout: actual=0 required=1");
      end
      @(negedge aclk);
      s_axi_arvalid = 1'b0;
   endtask

   task automatic collect_b();
      int n = 0;
      logic [1:0] e;
      while (!s_axi_bvalid && n < 50) begin @(negedge aclk); n++; end
      e = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
      vectors++;
      if (n >= 50) begin
         miscompares++;
         $display("FAIL bvalid_timeout: actual=0 required=1");
      end else if (s_axi_bresp !== e) begin
         miscompares++;
         $display("FAIL bresp: actual=%b required=%b", s_axi_bresp, e);
      end
      @(negedge aclk);
      if (s_axi_bready) begin
         vectors++;
         if (s_axi_bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL bvalid_single_pulse: actual=%b required=0", s_axi_bvalid);
         end
      end
   endtask

   task automatic collect_r();
      int n = 0;
      logic [33:0] e;
      while (!s_axi_rvalid && n < 50) begin @(negedge aclk); n++; end
      e = (exp_r.size() > 0) ? exp_r.pop_front() : 34'bx;
      vectors++;
      if (n >= 50) begin
         miscompares++;
         $display("FAIL rvalid_timeout: actual=0 required=1");
      end else if ({s_axi_rresp, s_axi_rdata} !== e) begin
         miscompares++;
         $display("FAIL read_%03h: actual resp=%b data=%h required resp=%b data=%h",
                  s_axi_araddr, s_axi_rresp, s_axi_rdata, e[33:32], e[31:0]);
      end
      @(negedge aclk);
   endtask

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead);
      exp_b.push_back(is_mapped(a) ? 2'b00 : 2'b10);
      if (w_lead == 0) begin
         send_aw_w(a, d, s, 1'b0);
      end else begin
         send_w(d, s);
         repeat (w_lead) @(negedge aclk);
         send_aw(a);
      end
      collect_b();
   endtask

   task automatic axi_read(input logic [11:0] a, input logic [31:0] d);
      exp_r.push_back({is_mapped(a) ? 2'b00 : 2'b10, d});
      send_ar(a);
      collect_r();
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=%b required=%b", name, act, req);
      end
   endtask

   task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(negedge aclk);
      check_bit("rst_awready", s_axi_awready, 1'b0);
      check_bit("rst_wready", s_axi_wready, 1'b0);
      check_bit("rst_arready", s_axi_arready, 1'b0);
      check_bit("rst_bvalid", s_axi_bvalid, 1'b0);
      check_bit("rst_rvalid", s_axi_rvalid, 1'b0);
      check_word("rst_rdata", s_axi_rdata, 32'h0);
      check_bit("rst_start", start_o, 1'b0);
      check_bit("rst_irq", irq_o, 1'b0);
      check_word("rst_src", src_addr_o, 32'h0);
      areset = 1'b0;
      @(negedge aclk);
      check_bit("post_rst_awready", s_axi_awready, 1'b1);
      check_bit("post_rst_wready", s_axi_wready, 1'b1);
      axi_read(12'h014, 32'h0001_0000);
      axi_read(12'h008, 32'h0);
   endtask

   task automatic test_strobe();
      axi_write(12'h008, 32'h0, 4'hF, 0);
      axi_write(12'h008, 32'hDEAD_BEEF, 4'b0101, 0);
      axi_read(12'h008, 32'h00AD_00EF);
      check_word("src_addr_o", src_addr_o, 32'h00AD_00EF);
      axi_write(12'h008, 32'h0, 4'hF, 0);
      axi_write(12'h008, 32'hDEAD_BEEF, 4'b0101, 3);
      axi_read(12'h008, 32'h00AD_00EF);
      check_word("src_addr_o_wfirst", src_addr_o, 32'h00AD_00EF);
      axi_write(12'h00C, 32'h1234_5678, 4'hF, 0);
      check_word("dst_addr_o", dst_addr_o, 32'h1234_5678);
      axi_write(12'h010, 32'hFFFF_FFFF, 4'hF, 2);
      axi_read(12'h010, 32'h0000_FFFF);
      check_word("len_o", {16'h0, len_o}, 32'h0000_FFFF);
   endtask

   task automatic test_start();
      busy_i = 1'b0;
      start_cnt = 0;
      axi_write(12'h000, 32'h1, 4'h1, 0);
      repeat (3) @(negedge aclk);
      check_word("start_pulses_idle", start_cnt, 32'd1);
      axi_read(12'h000, 32'h0);
      busy_i = 1'b1;
      start_cnt = 0;
      axi_write(12'h000, 32'h1, 4'h1, 0);
      repeat (3) @(negedge aclk);
      check_word("start_pulses_busy", start_cnt, 32'd0);
      axi_read(12'h004, 32'h1);
      busy_i = 1'b0;
   endtask

   task automatic test_irq();
      axi_write(12'h000, 32'h2, 4'h1, 0);
      axi_read(12'h000, 32'h2);
      done_i = 1'b1;
      @(negedge aclk);
      done_i = 1'b0;
      @(negedge aclk);
      check_bit("irq_after_done", irq_o, 1'b1);
      axi_read(12'h004, 32'h2);
      axi_write(12'h004, 32'h2, 4'h1, 0);
      @(negedge aclk);
      check_bit("irq_after_w1c", irq_o, 1'b0);
      axi_read(12'h004, 32'h0);
      exp_b.push_back(2'b00);
      send_aw_w(12'h004, 32'h2, 4'h1, 1'b1);
      collect_b();
      axi_read(12'h004, 32'h2);
      check_bit("irq_set_wins", irq_o, 1'b1);
      axi_write(12'h004, 32'h2, 4'h1, 0);
      axi_write(12'h000, 32'h0, 4'h1, 0);
      @(negedge aclk);
      check_bit("irq_cleared", irq_o, 1'b0);
   endtask

   task automatic test_unmapped();
      start_cnt = 0;
      axi_write(12'h020, 32'hFFFF_FFFF, 4'hF, 0);
      axi_read(12'h020, 32'h0);
      axi_read(12'h000, 32'h0);
      axi_read(12'h008, 32'h00AD_00EF);
      check_word("unmapped_start", start_cnt, 32'd0);
      axi_write(12'h018, 32'h5, 4'hF, 0);
      axi_read(12'h01C, 32'h0);
      axi_write(12'h014, 32'hFFFF_FFFF, 4'hF, 0);
      axi_read(12'h014, 32'h0001_0000);
   endtask

   task automatic test_stall();
      int n = 0;
      s_axi_bready = 1'b0;
      exp_b.push_back(2'b00);
      send_aw_w(12'h00C, 32'hCAFE_F00D, 4'hF, 1'b0);
      while (!s_axi_bvalid && n < 50) begin @(negedge aclk); n++; end
      for (int i = 0; i < 5; i++) begin
         check_bit("stall_bvalid", s_axi_bvalid, 1'b1);
         check_bit("stall_awready", s_axi_awready, 1'b0);
         check_bit("stall_wready", s_axi_wready, 1'b0);
         @(negedge aclk);
      end
      s_axi_bready = 1'b1;
      collect_b();
      check_word("stall_dst", dst_addr_o, 32'hCAFE_F00D);
      s_axi_rready = 1'b0;
      exp_r.push_back({2'b00, 32'hCAFE_F00D});
      send_ar(12'h00C);
      n = 0;
      while (!s_axi_rvalid && n < 50) begin @(negedge aclk); n++; end
      for (int i = 0; i < 5; i++) begin
         check_bit("stall_rvalid", s_axi_rvalid, 1'b1);
         check_word("stall_rdata", s_axi_rdata, 32'hCAFE_F00D);
         check_bit("stall_arready", s_axi_arready, 1'b0);
         @(negedge aclk);
      end
      s_axi_rready = 1'b1;
      collect_r();
   endtask

   task automatic test_reset_mid_write();
      send_w(32'h5555_5555, 4'hF);
      s_axi_awaddr = 12'h008;
      s_axi_awvalid = 1'b1;
      @(negedge aclk);
      s_axi_awvalid = 1'b0;
      areset = 1'b1;
      @(negedge aclk);
      check_bit("midrst_bvalid", s_axi_bvalid, 1'b0);
      check_bit("midrst_rvalid", s_axi_rvalid, 1'b0);
      check_bit("midrst_awready", s_axi_awready, 1'b0);
      check_word("midrst_src", src_addr_o, 32'h0);
      areset = 1'b0;
      @(negedge aclk);
      axi_read(12'h008, 32'h0);
      axi_write(12'h008, 32'h0000_1234, 4'hF, 0);
      axi_read(12'h008, 32'h0000_1234);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         axi_write(12'h010, 32'(i * 16'h1111), 4'h3, 0);
      end
      axi_read(12'h010, 32'h0000_3333);
      check_word("queues_drained", exp_b.size() + exp_r.size(), 32'd0);
   endtask

   initial begin
      test_reset();
      test_strobe();
      test_start();
      test_irq();
      test_unmapped();
      test_stall();
      test_reset_mid_write();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dct_ctrl_axil_slave.md
# dct_ctrl_axil_slave

AXI4-Lite responder (slave) that terminates the 12-bit-address, 32-bit-data control bus driven by the DMA/accelerator control master. It holds the 4x4 2D-DCT accelerator's control and status register file. It drives the start pulse and the transfer descriptors (source, destination, length) into the DMA/core, and collects busy/done status back into the register file.

## Interface
- `ADDR_W`, default 12: AXI address width; only `addr[4:2]` are decoded, `addr[1:0]` are ignored.
- `VERSION`, default 32'h0001_0000: value returned by the VERSION register.
- `aclk` input 1: single clock; all logic is on the rising edge.
- `areset` input 1: synchronous, active-high reset.
- `s_axi_awaddr` in ADDR_W, `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_araddr` in ADDR_W, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.
- `start_o` out 1: one-cycle start pulse to the DMA/core.
- `src_addr_o` out 32, `dst_addr_o` out 32, `len_o` out 16: transfer descriptor outputs.
- `busy_i` in 1: core/DMA busy level.
- `done_i` in 1: one-cycle completion pulse.
- `irq_o` out 1: level interrupt.

## Operation
- Register map (word offsets):
  - 0x000 CTRL: bit0 START is write-1-pulse and reads 0; bit1 IRQ_EN is RW.
  - 0x004 STATUS: bit0 BUSY is RO (mirrors `busy_i`); bit1 DONE is sticky and write-1-to-clear.
  - 0x008 SRC_ADDR: RW 32.
  - 0x00C DST_ADDR: RW 32.
  - 0x010 LEN: RW, bits [15:0]; upper bits read 0.
  - 0x014 VERSION: RO.
- Unused bits read 0.
- Unmapped offsets (0x018 and above): writes are ignored and return SLVERR (2'b10); reads return rdata=0 with SLVERR. All mapped accesses return OKAY (2'b00).
- Writes to RO registers (STATUS bit0, VERSION) are ignored and return OKAY.
- `wstrb` byte enables apply to SRC_ADDR, DST_ADDR and LEN. For CTRL and STATUS, a bit acts only if byte 0 is strobed.
- Write path: AW and W are captured independently, in either order, into holding registers.
  - Each ready is high while its holding register is empty and `bvalid` is 0.
  - When both are held, the write executes and `bvalid` is set. Both holding registers clear on the B handshake.
- Read path: `arready` = !`rvalid`. On the AR handshake, the addressed register is sampled into `rdata` and `rvalid` is set. Both are held until `rready`.
- START: writing 1 with `busy_i`=0 produces `start_o`=1 for exactly one cycle. Writing 1 with `busy_i`=1 is ignored: no pulse, OKAY response.
- DONE is set by `done_i` and cleared by a W1C write. If set and clear occur in the same cycle, set wins.
- `irq_o` = IRQ_EN & DONE, registered.
- Reset values:
  - all ready/valid outputs 0; bresp and rresp 0; rdata 0.
  - `start_o` 0; SRC_ADDR, DST_ADDR and LEN 0; IRQ_EN 0; DONE 0; `irq_o` 0.
  - `awready` and `wready` go to 1 in the first cycle after reset deasserts.
- Reset mid-transaction: pending AW/W/B/R state is discarded and no register is updated.

## Timing
- Write latency: if the later of the AW and W handshakes completes at edge N, the register updates and `bvalid` rises at edge N+1.
- A START write drives `start_o` high for the cycle following edge N+1.
- AW and W are accepted in the same cycle when both valids are presented together.
- Back-to-back writes are throttled to one per B handshake. Minimum is 3 cycles per write with `bready` held at 1.
- Read latency: AR handshake at edge N gives `rvalid` and `rdata` valid after edge N. Reads are one-outstanding, so throughput is one per 2 cycles with `rready`=1.
- Read and write channels are independent and may complete in the same cycle. A read of STATUS in the same cycle as a DONE clear returns the pre-clear value.
- `irq_o` follows a DONE or IRQ_EN change by one cycle.
- Outputs never change while their valid is high and ready is low (AXI stability rule).

## Test plan
- After reset: read 0x014 -> rdata=32'h0001_0000, OKAY. Read 0x008 -> 0.
- Write 0x008=32'hDEAD_BEEF with wstrb=4'b0101 after a prior write of 0 -> readback 32'h00AD_00EF, and `src_addr_o` matches. Repeat with W presented 3 cycles before AW -> same result, and a single `bvalid` pulse occurs.
- Write CTRL=32'h1 with `busy_i`=0 -> exactly one `start_o` cycle. Repeat with `busy_i`=1 -> no pulse, OKAY.
- Set IRQ_EN, then pulse `done_i` -> STATUS reads 32'h2 and `irq_o`=1. Write STATUS=32'h2 -> `irq_o`=0. Apply W1C in the same cycle as `done_i` -> DONE stays 1.
- Write and read offset 0x020 -> bresp=2'b10 and rresp=2'b10, rdata=0, no register changed.
- Hold `bready`/`rready` low for 5 cycles -> bvalid, rvalid and rdata are stable and no new AW/W/AR is accepted. Assert `areset` mid-write -> all valids are 0 next cycle and the target register is unchanged.
